// File: rtl/ipv4_if.sv
// IPv4 header decoder bus: byte stream in, decoded header fields and payload stream out.
interface ipv4_if;
   logic        valid;
   logic [7:0]  din;
   logic [31:0] src_ip;
   logic [31:0] dst_ip;
   logic [7:0]  protocol;
   logic [15:0] total_length;
   logic        hdr_done;
   logic        err;
   logic [7:0]  dout;
   logic        dout_valid;

   // Byte source / result consumer side
   modport master (
      output valid, din,
      input  src_ip, dst_ip, protocol, total_length, hdr_done, err, dout, dout_valid
   );

   // Decoder side
   modport slave (
      input  valid, din,
      output src_ip, dst_ip, protocol, total_length, hdr_done, err, dout, dout_valid
   );
endinterface

// File: rtl/ipv4_decode.sv
// IPv4 header parser: validates the header (version, IHL, checksum, length,
// destination) and forwards exactly total_length - IHL*4 payload bytes.
module ipv4_decode #(
   parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0164,
   parameter bit          CHECK_DEST = 1'b1
) (
   input  logic   clk,
   input  logic   rst,
   ipv4_if.slave  bus
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      DROP
   } state_t;

   state_t              state,      state_n;
   logic [IDX_W-1:0]    idx,        idx_n;
   logic [CNT_W-1:0]    pay_cnt,    pay_cnt_n;
   logic [WORD_W-1:0]   csum,       csum_n;
   logic [BYTE_W-1:0]   hi_byte,    hi_byte_n;
   logic [3:0]          ihl,        ihl_n;
   // Set by reset so a packet cut by reset is ignored until valid drops
   logic                skip,       skip_n;
   logic [ADDR_W-1:0]   src_ip_q,   src_ip_n;
   logic [ADDR_W-1:0]   dst_ip_q,   dst_ip_n;
   logic [BYTE_W-1:0]   proto_q,    proto_n;
   logic [CNT_W-1:0]    tlen_q,     tlen_n;
   logic                hdr_done_q, hdr_done_n;
   logic                err_q,      err_n;
   logic [BYTE_W-1:0]   dout_q,     dout_n;
   logic                dout_vld_q, dout_vld_n;

   logic [WORD_W-1:0]   word_c;
   logic [WORD_W:0]     sum17_c;
   logic [WORD_W-1:0]   csum_add_c;
   logic [IDX_W-1:0]    hlen_c;
   logic                last_hdr_c;
   logic [ADDR_W-1:0]   dst_now_c;
   logic                dst_ok_c;
   logic                hdr_ok_c;

   // Header arithmetic: end-around-carry checksum step and final header checks
   always_comb begin
      word_c     = {hi_byte, bus.din};
      sum17_c    = {1'b0, csum} + {1'b0, word_c};
      csum_add_c = sum17_c[WORD_W-1:0] + WORD_W'(sum17_c[WORD_W]);
      hlen_c     = {2'b00, ihl, 2'b00};
      last_hdr_c = (idx == IDX_W'(hlen_c - IDX_W'(1)));
      dst_now_c  = (idx == IDX_W'(19)) ? {dst_ip_q[ADDR_W-1:BYTE_W], bus.din} : dst_ip_q;
      dst_ok_c   = (CHECK_DEST == 1'b0) || (dst_now_c == LOCAL_IP) ||
                   (dst_now_c == 32'hFFFF_FFFF);
      hdr_ok_c   = (csum_add_c == 16'hFFFF) && (tlen_q >= CNT_W'(hlen_c)) && dst_ok_c;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      pay_cnt_n  = pay_cnt;
      csum_n     = csum;
      hi_byte_n  = hi_byte;
      ihl_n      = ihl;
      skip_n     = skip;
      src_ip_n   = src_ip_q;
      dst_ip_n   = dst_ip_q;
      proto_n    = proto_q;
      tlen_n     = tlen_q;
      dout_n     = dout_q;
      err_n      = err_q;
      hdr_done_n = 1'b0;
      dout_vld_n = 1'b0;

      if (!bus.valid) begin
         state_n = IDLE;
         idx_n   = '0;
         err_n   = 1'b0;
         skip_n  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!skip) begin
                  idx_n     = IDX_W'(1);
                  ihl_n     = bus.din[3:0];
                  hi_byte_n = bus.din;
                  csum_n    = '0;
                  err_n     = 1'b0;
                  if ((bus.din[7:4] != 4'd4) || (bus.din[3:0] < 4'd5)) begin
                     state_n = DROP;
                     err_n   = 1'b1;
                  end else begin
                     state_n = HEADER;
                  end
               end
            end

            HEADER: begin
               idx_n = idx + IDX_W'(1);
               unique case (idx)
                  IDX_W'(2):  tlen_n[15:8]    = bus.din;
                  IDX_W'(3):  tlen_n[7:0]     = bus.din;
                  IDX_W'(9):  proto_n         = bus.din;
                  IDX_W'(12): src_ip_n[31:24] = bus.din;
                  IDX_W'(13): src_ip_n[23:16] = bus.din;
                  IDX_W'(14): src_ip_n[15:8]  = bus.din;
                  IDX_W'(15): src_ip_n[7:0]   = bus.din;
                  IDX_W'(16): dst_ip_n[31:24] = bus.din;
                  IDX_W'(17): dst_ip_n[23:16] = bus.din;
                  IDX_W'(18): dst_ip_n[15:8]  = bus.din;
                  IDX_W'(19): dst_ip_n[7:0]   = bus.din;
                  default: ;
               endcase
               if (idx[0]) begin
                  csum_n = csum_add_c;
               end else begin
                  hi_byte_n = bus.din;
               end
               if (last_hdr_c) begin
                  if (hdr_ok_c) begin
                     state_n    = PAYLOAD;
                     hdr_done_n = 1'b1;
                     pay_cnt_n  = CNT_W'(tlen_q - CNT_W'(hlen_c));
                  end else begin
                     state_n = DROP;
                     err_n   = 1'b1;
                  end
               end
            end

            PAYLOAD: begin
               if (pay_cnt != '0) begin
                  dout_n     = bus.din;
                  dout_vld_n = 1'b1;
                  pay_cnt_n  = pay_cnt - CNT_W'(1);
               end else begin
                  state_n = DROP;
               end
            end

            DROP: ;

            default: state_n = IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         pay_cnt    <= '0;
         csum       <= '0;
         hi_byte    <= '0;
         ihl        <= '0;
         skip       <= 1'b1;
         src_ip_q   <= '0;
         dst_ip_q   <= '0;
         proto_q    <= '0;
         tlen_q     <= '0;
         hdr_done_q <= 1'b0;
         err_q      <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         pay_cnt    <= pay_cnt_n;
         csum       <= csum_n;
         hi_byte    <= hi_byte_n;
         ihl        <= ihl_n;
         skip       <= skip_n;
         src_ip_q   <= src_ip_n;
         dst_ip_q   <= dst_ip_n;
         proto_q    <= proto_n;
         tlen_q     <= tlen_n;
         hdr_done_q <= hdr_done_n;
         err_q      <= err_n;
         dout_q     <= dout_n;
         dout_vld_q <= dout_vld_n;
      end
   end

   assign bus.src_ip       = src_ip_q;
   assign bus.dst_ip       = dst_ip_q;
   assign bus.protocol     = proto_q;
   assign bus.total_length = tlen_q;
   assign bus.hdr_done     = hdr_done_q;
   assign bus.err          = err_q;
   assign bus.dout         = dout_q;
   assign bus.dout_valid   = dout_vld_q;

endmodule

// File: tb/tb_ipv4_decode.sv
// Scoreboard bench for ipv4_decode: two instances (destination filter on/off)
// fed the same byte stream.
module tb_ipv4_decode;

   localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;
   localparam logic [31:0] SRC_IP   = 32'h0A00_0001;
   localparam logic [31:0] OTHER_IP = 32'hC0A8_0165;
   localparam logic [31:0] BCAST_IP = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst;

   ipv4_if bus_a ();
   ipv4_if bus_b ();

   ipv4_decode #(.LOCAL_IP(LOCAL_IP), .CHECK_DEST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   ipv4_decode #(.LOCAL_IP(LOCAL_IP), .CHECK_DEST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] b;
      int         c;
   } exp_t;
   exp_t sb[$];

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Per-packet observations
   int hdr_a = 0, hdr_cyc_a = -1, dv_a = 0, err_a = 0, err_first_a = -1;
   int hdr_b = 0, dv_b = 0;

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (bus_a.hdr_done) begin
         hdr_a++;
         hdr_cyc_a = cyc;
      end
      if (bus_a.err) begin
         if (err_a == 0) err_first_a = cyc;
         err_a++;
      end
      if (bus_a.dout_valid) begin
         dv_a++;
         if (sb.size() == 0) begin
            chk("sb_has_entry", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("dout", 32'(bus_a.dout), 32'(e.b));
            chk("dout_cycle", 32'(cyc), 32'(e.c));
         end
      end
      if (bus_b.hdr_done)   hdr_b++;
      if (bus_b.dout_valid) dv_b++;
   end

   logic [7:0] pkt [128];
   int plen;
   int phl;

   task automatic build(input int ihl, input logic [15:0] tlen, input logic [7:0] proto,
                        input logic [31:0] dst, input logic [15:0] xorv,
                        input int npay, input int npad);
      logic [16:0] s;
      logic [15:0] cs;
      phl = ihl * 4;
      pkt[0] = {4'd4, 4'(ihl)};
      pkt[1] = 8'h00;
      pkt[2] = tlen[15:8];
      pkt[3] = tlen[7:0];
      for (int i = 4; i < 8; i++) pkt[i] = 8'($urandom_range(0, 255));
      pkt[8]  = 8'h40;
      pkt[9]  = proto;
      pkt[10] = 8'h00;
      pkt[11] = 8'h00;
      pkt[12] = SRC_IP[31:24]; pkt[13] = SRC_IP[23:16];
      pkt[14] = SRC_IP[15:8];  pkt[15] = SRC_IP[7:0];
      pkt[16] = dst[31:24];    pkt[17] = dst[23:16];
      pkt[18] = dst[15:8];     pkt[19] = dst[7:0];
      for (int i = 20; i < phl; i++) pkt[i] = 8'($urandom_range(0, 255));
      s = '0;
      for (int i = 0; i < phl; i += 2) begin
         s = {1'b0, s[15:0]} + {1'b0, pkt[i], pkt[i+1]};
         s = 17'(s[15:0]) + 17'(s[16]);
      end
      cs = ~s[15:0] ^ xorv;
      pkt[10] = cs[15:8];
      pkt[11] = cs[7:0];
      for (int i = phl; i < phl + npay + npad; i++) pkt[i] = 8'($urandom_range(0, 255));
      plen = phl + npay + npad;
   endtask

   // Entered just after a rising edge; returns just after a rising edge with
   // exactly one idle cycle behind the packet.
   task automatic send(input string name, input int nsend, input int exp_hdr_a,
                       input int exp_hdr_b, input int fwd_a, input int fwd_b,
                       input int fail_idx, input int rst_at);
      int start;
      exp_t e;
      start = -1;
      for (int k = 0; k < nsend; k++) begin
         #1;
         if (k == 0) start = cyc;
         rst         = (k == rst_at);
         bus_a.valid = 1'b1;
         bus_b.valid = 1'b1;
         bus_a.din   = pkt[k];
         bus_b.din   = pkt[k];
         if (k >= phl && k < phl + fwd_a) begin
            e.b = pkt[k];
            e.c = cyc + 1;
            sb.push_back(e);
         end
         if (rst_at >= 0 && k == rst_at + 1) begin
            @(negedge clk);
            chk({name, "_rst_src"},  bus_a.src_ip, 32'h0);
            chk({name, "_rst_dst"},  bus_a.dst_ip, 32'h0);
            chk({name, "_rst_prot"}, 32'(bus_a.protocol), 32'h0);
            chk({name, "_rst_tlen"}, 32'(bus_a.total_length), 32'h0);
            chk({name, "_rst_dout"}, 32'(bus_a.dout), 32'h0);
            chk({name, "_rst_flags"},
                32'({bus_a.hdr_done, bus_a.err, bus_a.dout_valid}), 32'h0);
         end
         @(posedge clk);
      end
      #1;
      rst         = 1'b0;
      bus_a.valid = 1'b0;
      bus_b.valid = 1'b0;
      @(posedge clk);
      chk({name, "_hdr_a"}, 32'(hdr_a), 32'(exp_hdr_a));
      if (exp_hdr_a > 0) chk({name, "_hdr_cyc"}, 32'(hdr_cyc_a), 32'(start + phl));
      chk({name, "_dv_a"}, 32'(dv_a), 32'(fwd_a));
      chk({name, "_err_cycles"}, 32'(err_a), (fail_idx < 0) ? 32'd0 : 32'(nsend - fail_idx));
      if (fail_idx >= 0) chk({name, "_err_first"}, 32'(err_first_a), 32'(start + fail_idx + 1));
      chk({name, "_sb_left"}, 32'(sb.size()), 32'd0);
      chk({name, "_hdr_b"}, 32'(hdr_b), 32'(exp_hdr_b));
      chk({name, "_dv_b"}, 32'(dv_b), 32'(fwd_b));
      hdr_a = 0; hdr_cyc_a = -1; dv_a = 0; err_a = 0; err_first_a = -1;
      hdr_b = 0; dv_b = 0;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus_a.valid = 1'b0; bus_a.din = 8'h00;
      bus_b.valid = 1'b0; bus_b.din = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_src",  bus_a.src_ip, 32'h0);
      chk("reset_dst",  bus_a.dst_ip, 32'h0);
      chk("reset_tlen", 32'(bus_a.total_length), 32'h0);
      chk("reset_flags", 32'({bus_a.hdr_done, bus_a.err, bus_a.dout_valid, bus_a.dout}), 32'h0);
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk);

      // Nominal UDP packet with Ethernet padding
      build(5, 16'h0020, 8'h11, LOCAL_IP, 16'h0000, 12, 6);
      send("good", plen, 1, 1, 12, 12, -1, -1);
      chk("good_src",   bus_a.src_ip, SRC_IP);
      chk("good_dst",   bus_a.dst_ip, LOCAL_IP);
      chk("good_proto", 32'(bus_a.protocol), 32'h11);
      chk("good_tlen",  32'(bus_a.total_length), 32'h0020);

      // Corrupted checksum
      build(5, 16'h0020, 8'h11, LOCAL_IP, 16'h0001, 12, 6);
      send("badcsum", plen, 0, 0, 0, 0, 19, -1);

      // Foreign destination: rejected by filter, accepted without it
      build(5, 16'h0020, 8'h11, OTHER_IP, 16'h0000, 12, 6);
      send("otherdst", plen, 0, 1, 0, 12, 19, -1);

      // Broadcast destination
      build(5, 16'h0020, 8'h06, BCAST_IP, 16'h0000, 12, 2);
      send("bcast", plen, 1, 1, 12, 12, -1, -1);
      chk("bcast_dst",   bus_a.dst_ip, BCAST_IP);
      chk("bcast_proto", 32'(bus_a.protocol), 32'h06);

      // Header with one option word
      build(6, 16'h001C, 8'h11, LOCAL_IP, 16'h0000, 4, 2);
      send("opts", plen, 1, 1, 4, 4, -1, -1);

      // Bad version byte
      build(5, 16'h0020, 8'h11, LOCAL_IP, 16'h0000, 12, 0);
      pkt[0] = 8'h65;
      send("badver", 4, 0, 0, 0, 0, 0, -1);

      // Empty payload
      build(5, 16'h0014, 8'h11, LOCAL_IP, 16'h0000, 0, 4);
      send("empty", plen, 1, 1, 0, 0, -1, -1);

      // Truncated in header, then truncated in payload
      build(5, 16'h0020, 8'h11, LOCAL_IP, 16'h0000, 12, 0);
      send("cut_hdr", 10, 0, 0, 0, 0, -1, -1);
      build(5, 16'h0020, 8'h11, LOCAL_IP, 16'h0000, 12, 0);
      send("cut_pay", 25, 1, 1, 5, 5, -1, -1);

      // Reset during payload byte 3, then a normal packet
      build(5, 16'h0020, 8'h11, LOCAL_IP, 16'h0000, 12, 6);
      send("rstmid", plen, 1, 1, 3, 3, -1, 23);
      build(5, 16'h0020, 8'h11, LOCAL_IP, 16'h0000, 12, 6);
      send("after_rst", plen, 1, 1, 12, 12, -1, -1);
      chk("after_rst_tlen", 32'(bus_a.total_length), 32'h0020);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
